uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver: the receive-direction counterpart of the UART TX path in the same UART block. It recovers start, data (LSB first), optional parity, and stop bits from the serial line `RX_IN`, then presents the parallel byte with a one-cycle valid strobe or a one-cycle error strobe. It sits in the UART clock domain, between the synchronised serial input pin and the RX data synchroniser feeding the system domain.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `CLK` input 1: UART oversampling clock.
- `RST` input 1: asynchronous, active-high reset.
- `RX_IN` input 1: serial line, idle high; already synchronised to `CLK` upstream.
- `PAR_EN` input 1: 1 = frame carries a parity bit.
- `PAR_TYP` input 1: 0 = even, 1 = odd.
- `Prescale` input 6: oversampling ratio; legal values 8, 16, 32; any other value is treated as 8.
- `P_DATA` output DATA_WIDTH: last correctly received word; held until the next good frame.
- `data_valid` output 1: one-cycle pulse when `P_DATA` updates.
- `par_err` output 1: one-cycle pulse when a frame has a parity mismatch.
- `stp_err` output 1: one-cycle pulse when a frame has a low stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `edge_cnt` counts 0..Prescale-1 within each bit; `bit_cnt` counts 0..DATA_WIDTH-1 in DATA.
- Sampling: `RX_IN` is captured at edge_cnt = P/2-1, P/2 and P/2+1, where P = Prescale. The bit value is the 2-of-3 majority. It is consumed at edge_cnt = P-1 (end of bit).
- IDLE: when `RX_IN`=0, latch `PAR_EN`, `PAR_TYP` and `Prescale` for the whole frame, then go to START with edge_cnt=0 in the next cycle.
- START, end of bit:
  - majority=1: false start (glitch); return to IDLE with no strobe.
  - otherwise: go to DATA, bit_cnt=0.
- DATA: at each end of bit, shift the majority into the shift register LSB first. After bit DATA_WIDTH-1, go to PARITY if PAR_EN else STOP.
- PARITY: expected parity = XOR of the data bits (even), inverted for odd. A mismatch sets an internal frame-error flag for parity.
- STOP: majority=0 sets the stop-error flag. At end of bit, return to IDLE, and in the next cycle:
  - no errors: `P_DATA` ← shift register, `data_valid`=1.
  - any error: the corresponding `par_err` and/or `stp_err` = 1 (both may assert together); `P_DATA` is unchanged; `data_valid`=0.
- `data_valid` and the error strobes are mutually exclusive.
- Latched configuration ignores input changes mid-frame.

## Timing
- Reset values: state IDLE; counters 0; `P_DATA`=0; `data_valid`, `par_err`, `stp_err` all 0.
- Reset is asynchronous. Asserting `RST` mid-frame aborts the frame immediately, and no strobe follows on release.
- Let N = 1 + DATA_WIDTH + PAR_EN + 1 (bits per frame). Call the first cycle `RX_IN` is seen low in IDLE "cycle 0".
  - The frame occupies cycles 1..N·P.
  - Strobes fire in cycle N·P+1.
  - IDLE is re-entered in cycle N·P+1, and a start bit can be detected in that same cycle (back-to-back frames supported).
- False start: IDLE is re-entered in cycle P+1.
- All outputs are registered; no combinational path from `RX_IN` to any output.

## Structure
- Shared package `uart_pkg`:
  - state enum;
  - prescale constants (8/16/32);
  - parity-type constants (EVEN=0, ODD=1).
- The package is shared with the TX side.
- Sub-module `uart_rx_sampler` owns `edge_cnt`, the three sample registers, the majority vote, and an `end_of_bit` flag. The top holds the FSM, `bit_cnt`, the shift register, the parity/stop checks and the output registers.

## Test plan
- Prescale=8, PAR_EN=0, frame 0xA5 → `P_DATA`=0xA5, `data_valid` pulses once at cycle 81; no error strobes.
- Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity 0 → 0x3C valid. Repeat with parity 1 → `par_err` pulses, `P_DATA` keeps 0x3C.
- Prescale=32, PAR_EN=1, odd parity, stop bit driven low → `stp_err` pulses. With a wrong parity bit as well → `par_err` and `stp_err` pulse in the same cycle.
- 2-cycle low glitch on `RX_IN` at Prescale=16 → FSM back in IDLE by cycle 17; no strobes.
- Two back-to-back frames 0x01, 0xFF at Prescale=8 with no idle gap → two `data_valid` pulses 80 cycles apart; sample-point spikes of 1 cycle are rejected by the majority vote.
- `RST` asserted in DATA → outputs 0 within the same cycle. A following clean frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART RX and TX paths: FSM states, oversampling
// ratios and parity-type encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic logic [5:0] prescale_legal(input logic [5:0] p);
    logic [5:0] r;
    case (p)
      PRESCALE_16: r = PRESCALE_16;
      PRESCALE_32: r = PRESCALE_32;
      default:     r = PRESCALE_8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling timer: counts edges within a bit, captures three
// samples around the bit centre and reports their majority at end of bit.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] prescale,
  input  logic       rx_in,
  output logic       end_of_bit,
  output logic       majority
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic [2:0] samples;

  assign half       = prescale >> 1;
  assign end_of_bit = run && (edge_cnt == (prescale - 6'd1));
  assign majority   = (samples[0] & samples[1]) |
                      (samples[0] & samples[2]) |
                      (samples[1] & samples[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      samples  <= 3'b111;
    end else begin
      // Held at zero while idle so the first START cycle sees edge_cnt = 0.
      if (!run || end_of_bit) edge_cnt <= '0;
      else                    edge_cnt <= edge_cnt + 6'd1;
      if (run) begin
        if (edge_cnt == (half - 6'd1)) samples[0] <= rx_in;
        if (edge_cnt == half)          samples[1] <= rx_in;
        if (edge_cnt == (half + 6'd1)) samples[2] <= rx_in;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, bit counter, shift register, parity/stop checks
// and registered output strobes; bit timing comes from uart_rx_sampler.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level to start a frame
// START     | timing the start bit, high majority means a glitch
// DATA      | shifting in DATA_WIDTH bits, LSB first
// PARITY    | checking the parity bit against the received data
// STOP      | checking the stop bit, strobes follow on the next cycle
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_state_e state, state_nxt;

  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  cfg_par_en;
  logic                  cfg_par_typ;
  logic [5:0]            cfg_prescale;
  logic                  par_flag;
  logic                  exp_parity;

  logic run;
  logic end_of_bit;
  logic majority;

  logic frame_start;
  logic data_begin;
  logic shift_en;
  logic par_chk;
  logic frame_end;

  assign run = (state != ST_IDLE);

  uart_rx_sampler u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .run        (run),
    .prescale   (cfg_prescale),
    .rx_in      (RX_IN),
    .end_of_bit (end_of_bit),
    .majority   (majority)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
      ST_START:  if (end_of_bit) state_nxt = majority ? ST_IDLE : ST_DATA;
      ST_DATA:   if (end_of_bit && (bit_cnt == LAST_BIT))
                   state_nxt = cfg_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (end_of_bit) state_nxt = ST_STOP;
      ST_STOP:   if (end_of_bit) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    data_begin  = 1'b0;
    shift_en    = 1'b0;
    par_chk     = 1'b0;
    frame_end   = 1'b0;
    case (state)
      ST_IDLE:   frame_start = !RX_IN;
      ST_START:  data_begin  = end_of_bit && !majority;
      ST_DATA:   shift_en    = end_of_bit;
      ST_PARITY: par_chk     = end_of_bit;
      ST_STOP:   frame_end   = end_of_bit;
      default:   ;
    endcase
  end

  always_comb begin
    exp_parity = ^shift_reg;
    case (cfg_par_typ)
      PAR_EVEN: exp_parity = ^shift_reg;
      PAR_ODD:  exp_parity = ~^shift_reg;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cfg_par_en   <= 1'b0;
      cfg_par_typ  <= PAR_EVEN;
      cfg_prescale <= PRESCALE_8;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_flag     <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      // Configuration is frozen for the whole frame at start detection.
      if (frame_start) begin
        cfg_par_en   <= PAR_EN;
        cfg_par_typ  <= PAR_TYP;
        cfg_prescale <= prescale_legal(Prescale);
        par_flag     <= 1'b0;
      end
      if (data_begin) bit_cnt <= '0;
      if (shift_en) begin
        shift_reg <= {majority, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (par_chk) par_flag <= (majority != exp_parity);
      if (frame_end) begin
        if (!par_flag && majority) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          par_err <= par_flag;
          stp_err <= !majority;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames driven at line level, with
// strobe timing and data predicted from frame-length arithmetic.
module tb_uart_rx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          par_en;
  logic          par_typ;
  logic [5:0]    prescale;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_c = 0;
  logic [DW-1:0] p_exp = '0;

  int            exp_cyc[$];
  logic [2:0]    exp_kind[$];
  logic [DW-1:0] exp_data[$];
  int            got_cyc[$];
  logic [2:0]    got_kind[$];
  logic [DW-1:0] got_data[$];

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .Prescale   (prescale),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid || par_err || stp_err) begin
      got_cyc.push_back(cyc);
      got_kind.push_back({data_valid, par_err, stp_err});
      got_data.push_back(p_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_p(input logic [5:0] p);
    return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
  endfunction

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Optional one-cycle inversion landing on the centre sample point.
  task automatic send_bit(input logic v, input int p, input bit spike);
    if (spike) begin
      hold(v, p / 2 + 1);
      hold(~v, 1);
      hold(v, p - p / 2 - 2);
    end else begin
      hold(v, p);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps, input bit bad_par, input bit bad_stp,
                            input bit spikes);
    int p, n, fall_c, t0;
    logic pbit, pe_exp, se_exp;
    p = eff_p(ps);
    n = 2 + DW + (pe ? 1 : 0);
    par_en = pe; par_typ = pt; prescale = ps;
    fall_c = cyc + 1;
    t0 = (fall_c > ready_c) ? fall_c : ready_c;
    hold(1'b0, p);
    par_en = 1'($urandom); par_typ = 1'($urandom); prescale = 6'($urandom);
    for (int i = 0; i < DW; i++) send_bit(d[i], p, spikes);
    pbit = (^d) ^ pt ^ bad_par;
    if (pe) send_bit(pbit, p, spikes);
    par_en = pe; par_typ = pt; prescale = ps;
    send_bit(!bad_stp, p, spikes);
    pe_exp = pe & bad_par;
    se_exp = bad_stp;
    exp_cyc.push_back(t0 + n * p);
    if (!pe_exp && !se_exp) begin
      p_exp = d;
      exp_kind.push_back(3'b100);
    end else begin
      exp_kind.push_back({1'b0, pe_exp, se_exp});
    end
    exp_data.push_back(p_exp);
    ready_c = t0 + n * p + 1;
  endtask

  task automatic glitch(input int low_cycles, input logic [5:0] ps);
    int fall_c, t0;
    prescale = ps;
    fall_c = cyc + 1;
    t0 = (fall_c > ready_c) ? fall_c : ready_c;
    hold(1'b0, low_cycles);
    ready_c = t0 + eff_p(ps) + 1;
  endtask

  task automatic gap(input int n);
    hold(1'b1, n);
    chk("p_data_after_frame", 32'(p_data), 32'(p_exp));
  endtask

  initial begin
    logic [5:0] ps;
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8;
    repeat (3) @(negedge clk);
    chk("rst_p_data", 32'(p_data), 32'd0);
    chk("rst_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
    rst = 1'b0;
    hold(1'b1, 4);
    chk("idle_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);

    send_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0);  gap(3);
    send_frame(8'h3C, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0, 1'b0); gap(3);
    send_frame(8'h3C, 1'b1, 1'b0, 6'd16, 1'b1, 1'b0, 1'b0); gap(3);
    send_frame(8'h6B, 1'b1, 1'b1, 6'd32, 1'b0, 1'b1, 1'b0); gap(3);
    send_frame(8'h6B, 1'b1, 1'b1, 6'd32, 1'b1, 1'b1, 1'b0); gap(3);
    send_frame(8'hC3, 1'b1, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0); gap(3);

    glitch(2, 6'd16);
    hold(1'b1, 15);
    chk("glitch_no_strobe", 32'(got_cyc.size()), 32'(exp_cyc.size()));
    send_frame(8'h96, 1'b0, 1'b0, 6'd16, 1'b0, 1'b0, 1'b0); gap(3);

    send_frame(8'h01, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b1);
    gap(3);

    send_frame(8'h5A, 1'b0, 1'b0, 6'd13, 1'b0, 1'b0, 1'b0); gap(3);

    par_en = 1'b0; prescale = 6'd8;
    hold(1'b0, 8); hold(1'b1, 8); hold(1'b0, 8); hold(1'b1, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_p_data", 32'(p_data), 32'd0);
    chk("async_rst_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
    p_exp = '0;
    @(negedge clk);
    rx_in = 1'b1; rst = 1'b0;
    ready_c = cyc + 1;
    hold(1'b1, 3);
    chk("post_rst_no_strobe", 32'(got_cyc.size()), 32'(exp_cyc.size()));
    send_frame(8'h55, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0); gap(3);

    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0:       ps = 6'd8;
        1:       ps = 6'd16;
        2:       ps = 6'd32;
        default: ps = 6'($urandom);
      endcase
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), ps,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
      gap($urandom_range(2, 5));
    end

    hold(1'b1, 10);
    chk("event_count", 32'(got_cyc.size()), 32'(exp_cyc.size()));
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (i < got_cyc.size()) begin
        chk($sformatf("ev%0d_cycle", i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
        chk($sformatf("ev%0d_kind", i), 32'(got_kind[i]), 32'(exp_kind[i]));
        chk($sformatf("ev%0d_data", i), 32'(got_data[i]), 32'(exp_data[i]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
